brdg_retry_arbiter: RTL and testbench

- Schedules the single TLX command issue slot between three sources: new commands from the command encoder, the write-side retry queue and the read-side retry queue.
- A retry queue only signals "non-empty" (busy) and drives its valid in the same cycle it sees ready. The arbiter therefore offers ready to one queue at a time, for a bounded window.
- Retries take priority over new commands, subject to a starvation limit. Every issue consumes one TLX command credit.

---
 rtl/brdg_retry_arbiter_if.sv | 47 ++++
 rtl/brdg_retry_arbiter.sv | 172 +++++++++++++++++
 tb/tb_brdg_retry_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brdg_retry_arbiter_if.sv
// Issue-slot bus between the retry arbiter, the new-command source and the two retry queues.
// The master modport belongs to the arbiter; the slave modport belongs to the surrounding sources.
interface brdg_retry_arbiter_if #(
  parameter int TAGW = 7
);
  logic            cmd_req;
  logic [TAGW-1:0] cmd_tag;
  logic [1:0]      cmd_pos;
  logic            cmd_gnt;

  logic            rty0_busy;
  logic            rty0_rdy;
  logic            rty0_valid;
  logic [TAGW-1:0] rty0_tag;
  logic [1:0]      rty0_pos;

  logic            rty1_busy;
  logic            rty1_rdy;
  logic            rty1_valid;
  logic [TAGW-1:0] rty1_tag;
  logic [1:0]      rty1_pos;

  logic            out_valid;
  logic [1:0]      out_src;
  logic [TAGW-1:0] out_tag;
  logic [1:0]      out_pos;

  modport master (
    input  cmd_req, cmd_tag, cmd_pos,
    output cmd_gnt,
    input  rty0_busy, rty0_valid, rty0_tag, rty0_pos,
    output rty0_rdy,
    input  rty1_busy, rty1_valid, rty1_tag, rty1_pos,
    output rty1_rdy,
    output out_valid, out_src, out_tag, out_pos
  );

  modport slave (
    output cmd_req, cmd_tag, cmd_pos,
    input  cmd_gnt,
    output rty0_busy, rty0_valid, rty0_tag, rty0_pos,
    input  rty0_rdy,
    output rty1_busy, rty1_valid, rty1_tag, rty1_pos,
    input  rty1_rdy,
    input  out_valid, out_src, out_tag, out_pos
  );
endinterface

// File: rtl/brdg_retry_arbiter.sv
// Arbitrates the single TLX command issue slot between new commands and two retry queues,
// with round-robin retry offers, a starvation guard for new commands and credit accounting.
module brdg_retry_arbiter #(
  parameter int TAGW         = 7,
  parameter int CREDIT_W     = 6,
  parameter int OFFER_WIN    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CREDIT_W-1:0]   tlx_credit_init,
  input  logic                  tlx_credit_return,
  brdg_retry_arbiter_if.master  bus,
  output logic [CREDIT_W-1:0]   credit_cnt,
  output logic                  credit_err
);

  typedef enum logic [1:0] {IDLE, OFFER0, OFFER1, GNT_NEW} state_e;

  localparam logic [3:0] WIN_LAST   = 4'(OFFER_WIN - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [3:0]          offer_q, offer_d;
  logic [7:0]          starve_q, starve_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic                outv_q, outv_d;
  logic [1:0]          src_q, src_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic [1:0]          pos_q, pos_d;
  logic                issue;

  // Counts retries that overtook a waiting new command; any idle cmd_req clears it.
  function automatic logic [7:0] next_starve(input logic [7:0] cur, input logic req);
    if (!req) return 8'd0;
    if (cur >= STARVE_MAX) return STARVE_MAX;
    return cur + 8'd1;
  endfunction

  assign issue = ((state_q == OFFER0) && bus.rty0_valid) ||
                 ((state_q == OFFER1) && bus.rty1_valid) ||
                 (state_q == GNT_NEW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      offer_q  <= 4'd0;
      starve_q <= 8'd0;
      credit_q <= tlx_credit_init;
      err_q    <= 1'b0;
      outv_q   <= 1'b0;
      src_q    <= 2'd0;
      tag_q    <= '0;
      pos_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      offer_q  <= offer_d;
      starve_q <= starve_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      outv_q   <= outv_d;
      src_q    <= src_d;
      tag_q    <= tag_d;
      pos_q    <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if ((starve_q == STARVE_MAX) && bus.cmd_req) begin
          state_d = GNT_NEW;
        end else if (bus.rty0_busy || bus.rty1_busy) begin
          if (!rr_q) state_d = bus.rty0_busy ? OFFER0 : OFFER1;
          else       state_d = bus.rty1_busy ? OFFER1 : OFFER0;
        end else if (bus.cmd_req) begin
          state_d = GNT_NEW;
        end
      end
      OFFER0:  if (bus.rty0_valid || (offer_q == WIN_LAST)) state_d = IDLE;
      OFFER1:  if (bus.rty1_valid || (offer_q == WIN_LAST)) state_d = IDLE;
      GNT_NEW: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rty0_rdy = (state_q == OFFER0);
    bus.rty1_rdy = (state_q == OFFER1);
    bus.cmd_gnt  = (state_q == GNT_NEW);
  end

  // Capture of the issued command and the arbitration bookkeeping.
  always_comb begin
    rr_d     = rr_q;
    offer_d  = offer_q;
    starve_d = starve_q;
    outv_d   = 1'b0;
    src_d    = src_q;
    tag_d    = tag_q;
    pos_d    = pos_q;
    case (state_q)
      OFFER0: begin
        if (bus.rty0_valid) begin
          outv_d   = 1'b1;
          src_d    = 2'd1;
          tag_d    = bus.rty0_tag;
          pos_d    = bus.rty0_pos;
          rr_d     = 1'b1;
          offer_d  = 4'd0;
          starve_d = next_starve(starve_q, bus.cmd_req);
        end else if (offer_q == WIN_LAST) begin
          rr_d    = 1'b1;
          offer_d = 4'd0;
        end else begin
          offer_d = offer_q + 4'd1;
        end
      end
      OFFER1: begin
        if (bus.rty1_valid) begin
          outv_d   = 1'b1;
          src_d    = 2'd2;
          tag_d    = bus.rty1_tag;
          pos_d    = bus.rty1_pos;
          rr_d     = 1'b0;
          offer_d  = 4'd0;
          starve_d = next_starve(starve_q, bus.cmd_req);
        end else if (offer_q == WIN_LAST) begin
          rr_d    = 1'b0;
          offer_d = 4'd0;
        end else begin
          offer_d = offer_q + 4'd1;
        end
      end
      GNT_NEW: begin
        outv_d   = 1'b1;
        src_d    = 2'd0;
        tag_d    = bus.cmd_tag;
        pos_d    = bus.cmd_pos;
        starve_d = 8'd0;
      end
      default: ;
    endcase
  end

  // A return coinciding with an issue cancels out; a lone return at all-ones saturates.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (tlx_credit_return && !issue) begin
      if (&credit_q) err_d = 1'b1;
      else           credit_d = credit_q + 1'b1;
    end else if (!tlx_credit_return && issue) begin
      credit_d = credit_q - 1'b1;
    end
  end

  assign bus.out_valid = outv_q;
  assign bus.out_src   = src_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_pos   = pos_q;
  assign credit_cnt    = credit_q;
  assign credit_err    = err_q;

endmodule

// File: tb/tb_brdg_retry_arbiter.sv
// Bench for brdg_retry_arbiter: directed scenarios plus randomized segments scored against an
// issue-order model; a monitor pops expected issues whenever out_valid is presented.
module tb_brdg_retry_arbiter;
  localparam int TAGW = 7;
  localparam int CW   = 6;
  localparam int WIN  = 4;
  localparam int L    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] init = 6'd0;
  logic          ret = 1'b0;
  logic [CW-1:0] credit_cnt;
  logic          credit_err;
  logic          b0 = 1'b0, b1 = 1'b0, c = 1'b0, en0 = 1'b0, en1 = 1'b0;

  always #5 clk = ~clk;

  brdg_retry_arbiter_if #(.TAGW(TAGW)) bus ();

  brdg_retry_arbiter #(.TAGW(TAGW), .CREDIT_W(CW), .OFFER_WIN(WIN), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst), .tlx_credit_init(init), .tlx_credit_return(ret),
    .bus(bus), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  assign bus.rty0_busy = b0;
  assign bus.rty1_busy = b1;
  assign bus.cmd_req   = c;

  logic [8:0]  w0 [64];
  logic [8:0]  w1 [64];
  logic [8:0]  wc [64];
  int          k0, k1, kc;
  logic        gpend;
  logic [10:0] expq [$];
  int          npop = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source agents: a retry queue answers valid on the first rdy cycle when enabled;
  // each source presents its own pre-drawn tag/pos sequence, advancing after each handshake.
  initial begin
    k0 = 0; k1 = 0; kc = 0; gpend = 1'b0;
    bus.rty0_valid = 1'b0; bus.rty1_valid = 1'b0;
    bus.rty0_tag = '0; bus.rty0_pos = '0; bus.rty1_tag = '0; bus.rty1_pos = '0;
    bus.cmd_tag = '0; bus.cmd_pos = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k0 = 0; k1 = 0; kc = 0; gpend = 1'b0;
        bus.rty0_valid = 1'b0; bus.rty1_valid = 1'b0;
      end else begin
        if (bus.rty0_valid) begin k0++; bus.rty0_valid = 1'b0; end
        if (bus.rty1_valid) begin k1++; bus.rty1_valid = 1'b0; end
        if (gpend) begin kc++; gpend = 1'b0; end
        if (bus.rty0_rdy && en0) bus.rty0_valid = 1'b1;
        if (bus.rty1_rdy && en1) bus.rty1_valid = 1'b1;
        if (bus.cmd_gnt) gpend = 1'b1;
      end
      {bus.rty0_tag, bus.rty0_pos} = w0[k0 & 63];
      {bus.rty1_tag, bus.rty1_pos} = w1[k1 & 63];
      {bus.cmd_tag, bus.cmd_pos}   = wc[kc & 63];
    end
  end

  // Monitor: grant exclusivity every cycle, and in-order comparison of every issue.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("grant_exclusive", int'(bus.rty0_rdy) + int'(bus.rty1_rdy) + int'(bus.cmd_gnt) > 1 ? 1 : 0, 0);
        if (bus.out_valid) begin
          if (expq.size() == 0) begin
            chk("unexpected_issue", int'({bus.out_src, bus.out_tag, bus.out_pos}), -1);
          end else begin
            e = expq.pop_front();
            chk("issue", int'({bus.out_src, bus.out_tag, bus.out_pos}), int'(e));
          end
          npop++;
        end
      end
    end
  end

  task automatic do_reset(input logic [CW-1:0] v);
    @(negedge clk);
    rst  = 1'b1;
    init = v;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int src, input logic [8:0] w);
    expq.push_back({2'(src), w});
  endtask

  task automatic wait_pops(input int base, input int n, input int bound, input string name);
    int cyc = 0;
    while ((npop - base) < n && cyc < bound) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk(name, npop - base, n);
  endtask

  task automatic quiesce();
    b0 = 1'b0; b1 = 1'b0; c = 1'b0;
  endtask

  // Issue-order model: retries round-robin ahead of new commands, except that after L
  // retries overtook a pending command the command goes next. Inputs held stable.
  task automatic model(input logic mb0, input logic mb1, input logic mc, input int n);
    int rr = 0, st = 0, i0 = 0, i1 = 0, ic = 0, x;
    for (int i = 0; i < n; i++) begin
      if (st == L && mc) begin
        push(0, wc[ic]); ic++; st = 0;
      end else if (mb0 || mb1) begin
        if (rr == 0) x = mb0 ? 0 : 1;
        else         x = mb1 ? 1 : 0;
        if (x == 0) begin push(1, w0[i0]); i0++; end
        else        begin push(2, w1[i1]); i1++; end
        rr = 1 - x;
        st = mc ? ((st + 1 > L) ? L : st + 1) : 0;
      end else begin
        push(0, wc[ic]); ic++; st = 0;
      end
    end
  endtask

  initial begin
    int base, mask, gn, cnt, rmin, rets, seg_init;
    for (int i = 0; i < 64; i++) begin
      w0[i] = 9'($urandom); w1[i] = 9'($urandom); wc[i] = 9'($urandom);
    end

    // Reset state and credit saturation.
    do_reset(6'd63);
    @(negedge clk); #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_rdy", int'(bus.rty0_rdy) + int'(bus.rty1_rdy) + int'(bus.cmd_gnt), 0);
    chk("rst_credit", int'(credit_cnt), 63);
    chk("rst_err", int'(credit_err), 0);
    ret = 1'b1; @(negedge clk); ret = 1'b0; #1;
    chk("sat_credit", int'(credit_cnt), 63);
    chk("sat_err", int'(credit_err), 1);
    repeat (5) @(negedge clk); #1;
    chk("sat_err_sticky", int'(credit_err), 1);
    do_reset(6'd10); #1;
    chk("err_cleared", int'(credit_err), 0);
    chk("reload_credit", int'(credit_cnt), 10);

    // Three credits, new commands only: issues at cycles 2, 4, 6 then stall.
    c = 1'b1;
    base = npop;
    for (int i = 0; i < 4; i++) push(0, wc[i]);
    do_reset(6'd3);
    mask = 0; gn = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk); #1;
      if (cyc <= 8 && bus.out_valid) mask |= (1 << cyc);
      if (cyc > 7 && bus.cmd_gnt) gn++;
    end
    chk("new_issue_cycles", mask, 84);
    chk("stall_no_gnt", gn, 0);
    chk("credit_zero", int'(credit_cnt), 0);
    ret = 1'b1; @(negedge clk); ret = 1'b0;
    wait_pops(base, 4, 10, "after_return_issue");
    chk("credit_zero_again", int'(credit_cnt), 0);
    quiesce();

    // Both retries ready immediately: strict alternation, four credits spent.
    b0 = 1'b1; b1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    push(1, w0[0]); push(2, w1[0]); push(1, w0[1]); push(2, w1[1]);
    do_reset(6'd10);
    base = npop;
    wait_pops(base, 4, 40, "rr_pops");
    quiesce();
    repeat (3) @(negedge clk); #1;
    chk("rr_credit", int'(credit_cnt), 6);

    // rty0 in backoff: a four-cycle offer window, then rty1 is served.
    b0 = 1'b1; b1 = 1'b1; en0 = 1'b0; en1 = 1'b1;
    push(2, w1[0]);
    do_reset(6'd5);
    base = npop; cnt = 0; rmin = 63;
    for (int cyc = 0; cyc < 30 && npop == base; cyc++) begin
      @(negedge clk); #1;
      if (bus.rty0_rdy) begin
        cnt++;
        if (int'(credit_cnt) < rmin) rmin = int'(credit_cnt);
      end
    end
    quiesce();
    chk("offer_window", cnt, WIN);
    chk("offer_credit", rmin, 5);
    chk("offer_pop", npop - base, 1);
    repeat (2) @(negedge clk); #1;
    chk("offer_credit_after", int'(credit_cnt), 4);

    // Starvation guard with L=2.
    b0 = 1'b1; b1 = 1'b1; c = 1'b1; en0 = 1'b1; en1 = 1'b1;
    push(1, w0[0]); push(2, w1[0]); push(0, wc[0]);
    push(1, w0[1]); push(2, w1[1]); push(0, wc[1]);
    do_reset(6'd20);
    base = npop; gn = 0;
    for (int cyc = 0; cyc < 60 && (npop - base) < 6; cyc++) begin
      @(negedge clk); #1;
      if (bus.cmd_gnt) gn++;
    end
    quiesce();
    chk("starve_pops", npop - base, 6);
    chk("starve_gnts", gn, 2);

    // Credit return coinciding with the rty1 handshake.
    b1 = 1'b1; en1 = 1'b1;
    push(2, w1[0]);
    do_reset(6'd5);
    base = npop; cnt = 0;
    while (!bus.rty1_rdy && cnt < 10) begin @(negedge clk); #1; cnt++; end
    chk("rty1_offered", int'(bus.rty1_rdy), 1);
    ret = 1'b1;
    @(negedge clk); ret = 1'b0; quiesce();
    repeat (2) @(negedge clk); #1;
    chk("ret_and_issue_credit", int'(credit_cnt), 5);
    chk("ret_and_issue_pop", npop - base, 1);

    // Reset landing on the rty0 handshake cycle aborts it.
    b0 = 1'b1; en0 = 1'b1;
    do_reset(6'd7);
    base = npop; cnt = 0;
    while (cnt < 10) begin @(negedge clk); cnt++; if (bus.rty0_rdy) break; end
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_credit", int'(credit_cnt), 7);
    chk("abort_rdy", int'(bus.rty0_rdy), 0);
    b0 = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("abort_credit_after", int'(credit_cnt), 7);
    chk("abort_no_issue", npop - base, 0);

    // Randomized segments with stable request sets and random credit returns.
    for (int s = 0; s < 10; s++) begin
      logic rb0, rb1, rc;
      do begin
        rb0 = 1'($urandom); rb1 = 1'($urandom); rc = 1'($urandom);
      end while (!(rb0 || rb1 || rc));
      seg_init = int'($urandom_range(25, 10));
      model(rb0, rb1, rc, 12);
      b0 = rb0; b1 = rb1; c = rc; en0 = 1'b1; en1 = 1'b1;
      do_reset(6'(seg_init));
      base = npop; rets = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        @(negedge clk); #1;
        if ((npop - base) >= 12) break;
        ret = ($urandom_range(3, 0) == 0);
        rets += int'(ret);
      end
      ret = 1'b0;
      quiesce();
      repeat (3) @(negedge clk); #1;
      chk("rand_pops", npop - base, 12);
      chk("rand_credit", int'(credit_cnt), seg_init + rets - 12);
      chk("rand_queue_empty", expq.size(), 0);
      expq.delete();
    end

    chk("final_queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
